// File: rtl/seq_multiplier_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller.
package seq_multiplier_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/n_bit_adder.sv
// Combinational N-bit ripple-carry adder; 'of' is the carry out of the top bit.
module n_bit_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] out,
  output logic         of
);

  logic [N:0] carry;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    out      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      out[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    of = carry[N];
  end

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Sequential unsigned shift-add multiplier: one shared N-bit adder stepped over N cycles,
// with a start/done handshake and a registered 2N-bit product.
module seq_multiplier_ctrl
  import seq_multiplier_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int              CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     acc;
  logic [N-1:0]     mq;
  logic [N-1:0]     mcand;
  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last;

  assign addend = mq[0] ? mcand : '0;
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == LAST);

  n_bit_adder #(.N(N)) u_adder (
    .a   (acc),
    .b   (addend),
    .cin (1'b0),
    .out (sum),
    .of  (carry)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // The carry is shifted in at the top so acc+mcand >= 2^N is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      cnt   <= '0;
      p     <= '0;
    end else if (accept) begin
      mcand <= a;
      mq    <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= {carry, sum[N-1:1]};
      mq  <= {sum[0], mq[N-1:1]};
      cnt <= cnt + 1'b1;
      if (last) p <= {carry, sum, mq[N-1:1]};
    end
  end

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Self-checking bench for seq_multiplier_ctrl: N=4 against a cycle-level reference model,
// plus directed N=8 checks.
module tb_seq_multiplier_ctrl;

  localparam int N4 = 4;
  localparam int N8 = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_multiplier_ctrl #(.N(N4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  seq_multiplier_ctrl #(.N(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted request finishes N edges later with a*b; nothing else matters.
  int         m_left  = 0;
  logic [7:0] m_pending;
  logic [7:0] m_p     = '0;
  bit         m_done  = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left  = 0;
      m_done  = 1'b0;
      m_p     = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_p    = m_pending;
          m_done = 1'b1;
        end
      end else begin
        m_done = 1'b0;
        if (start4) begin
          m_pending = 8'(a4) * 8'(b4);
          m_left    = N4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_busy", 64'(busy4), 64'(m_left > 0));
      check("model_done", 64'(done4), 64'(m_done));
      check("model_p",    64'(p4),    64'(m_p));
    end
  end

  task automatic wait_done4(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done4) begin
        got = 1'b1;
        break;
      end
      if (busy4) busy_cnt++;
      @(negedge clk);
    end
    if (!got) check("done4_timeout", 64'd0, 64'd1);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int busy_cnt);
    bit got;
    @(negedge clk);
    start4 = 1'b1;
    a4     = a;
    b4     = b;
    @(negedge clk);
    start4 = 1'b0;
    wait_done4(busy_cnt, got);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int cycles);
    bit got;
    got = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 1;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        got = 1'b1;
        break;
      end
      cycles++;
      @(negedge clk);
    end
    if (!got) check("done8_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int dcount;
    int cyc;
    bit got;
    logic [7:0] p_seen;

    reset  = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy4), 64'd0);
    check("reset_done", 64'(done4), 64'd0);
    check("reset_p",    64'(p4),    64'd0);

    // 13*11: four busy cycles then done with 143
    run4(4'd13, 4'd11, bc);
    check("busy_cycles_13x11", 64'(bc), 64'd4);
    check("p_13x11", 64'(p4), 64'h8F);

    run4(4'd15, 4'd15, bc);
    check("p_15x15_carry", 64'(p4), 64'hE1);
    run4(4'd0, 4'd9, bc);
    check("p_0x9", 64'(p4), 64'd0);
    run4(4'd9, 4'd1, bc);
    check("p_9x1", 64'(p4), 64'd9);

    // start held and operands changed during RUN must be ignored
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7;
    @(negedge clk);
    @(negedge clk);
    start4 = 1'b0;
    dcount = 0;
    p_seen = '0;
    repeat (12) begin
      if (done4) begin
        dcount++;
        p_seen = p4;
      end
      @(negedge clk);
    end
    check("held_start_done_count", 64'(dcount), 64'd1);
    check("held_start_p", 64'(p_seen), 64'd15);

    // reset in the second RUN cycle aborts without a done pulse
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd10;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy4), 64'd0);
    check("abort_done", 64'(done4), 64'd0);
    check("abort_p",    64'(p4),    64'd0);
    dcount = 0;
    repeat (10) begin
      if (done4) dcount++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    run4(4'd5, 4'd6, bc);
    check("after_abort_p", 64'(p4), 64'd30);

    // back-to-back: new start in the DONE cycle enters RUN immediately
    run4(4'd2, 4'd3, bc);
    check("b2b_first_p", 64'(p4), 64'd6);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd7;
    @(negedge clk);
    start4 = 1'b0;
    check("b2b_no_idle", 64'(busy4), 64'd1);
    check("b2b_hold_p", 64'(p4), 64'd6);
    wait_done4(bc, got);
    check("b2b_second_p", 64'(p4), 64'd42);

    // exhaustive N=4 sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), bc);
        check("sweep_p", 64'(p4), 64'(i * j));
      end
    end

    // random start/operand/reset traffic, checked only by the reference model
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start4 = 1'($urandom_range(0, 1));
      a4     = 4'($urandom);
      b4     = 4'($urandom);
      reset  = ($urandom_range(0, 40) == 0);
    end
    @(negedge clk);
    reset  = 1'b0;
    start4 = 1'b0;
    repeat (8) @(negedge clk);

    // N=8 instance
    run8(8'd255, 8'd255, cyc);
    check("n8_latency", 64'(cyc), 64'd9);
    check("n8_p_255x255", 64'(p8), 64'hFE01);
    run8(8'd200, 8'd3, cyc);
    check("n8_p_200x3", 64'(p8), 64'd600);
    for (int k = 0; k < 10; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8(ra, rb, cyc);
      check("n8_rand_p", 64'(p8), 64'(16'(ra) * 16'(rb)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_ctrl.md
Name: seq_multiplier_ctrl

Overview:
Multi-cycle shift-add multiplier. It sequences one shared N-bit ripple adder over N cycles instead of the N-1 adders a combinational array multiplier needs. It sits between a requester (start/done handshake) and the arithmetic datapath, trading latency for area. Its product must match the combinational array multiplier bit-for-bit.

Parameters:
N, 4, operand width in bits; legal range 2..16; product width is 2N.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; no other clock or async reset
start  input  1  request; sampled only in IDLE or DONE
a  input  N  multiplicand, captured on accepted start
b  input  N  multiplier, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  single-cycle pulse; p valid and stable from this cycle
p  output  2N  registered product a*b; holds until the next result is written

Behaviour:
- Reset (edge with reset=1): state=IDLE; p=0, done=0, busy=0; acc, mq, mcand, cnt cleared. Reset overrides start. Reset mid-RUN aborts with no done pulse.
- Internal registers:
  - acc[N-1:0]: upper partial product.
  - mq[N-1:0]: multiplier, shifting into the lower product.
  - mcand[N-1:0]: latched multiplicand.
  - cnt: width clog2(N+1).
- IDLE: if start=1 at edge, then mcand<=a, mq<=b, acc<=0, cnt<=0, state<=RUN; otherwise hold.
- RUN: each edge:
  - sum = acc + (mq[0] ? mcand : 0), with carry out c.
  - {acc, mq} <= {c, sum, mq[N-1:1]}, a 2N+1-bit right shift by 1.
  - cnt<=cnt+1.
  - On the edge where cnt==N-1: p<={next acc, next mq}, state<=DONE.
  - start is ignored in RUN; a, b changes are ignored after capture.
- DONE: done=1 for exactly this cycle.
  - If start=1, accept the new operands as in IDLE and go to RUN (back-to-back, no idle bubble).
  - Otherwise go to IDLE.
  - p keeps the last result until the next DONE entry.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge E0+N. Throughput is one product per N+1 cycles.
- busy = (state==RUN). done = (state==DONE), decoded from registered state with no combinational path from inputs.
- Width rules:
  - Unsigned only.
  - Carry c must be kept; dropping it corrupts results when acc+mcand ≥ 2^N (e.g. 15*15).
  - Max product (2^N-1)^2 fits in 2N bits, so there is no overflow flag.
- An illegal state encoding returns to IDLE on the next edge.

Decomposition:
- Shared header mult_ctrl_defs.vh:
  - state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - STATE_W=2
- One sub-module: the codebase's combinational n_bit_adder (ports a, b, cin, out, of), instantiated once with cin=0 and of used as carry c.
- Controller FSM, counter and shift registers stay in this module as plain registers.

Test Plan:
- N=4, a=13, b=11, start 1 cycle -> busy high 4 cycles, done pulse on 5th cycle after start, p=143 (8'h8F).
- N=4, a=15, b=15 -> p=225 (8'hE1), which checks adder carry retention; also a=0, b=9 -> p=0 and a=9, b=1 -> p=9.
- Start held high with new a/b during RUN (a=3, b=5, then a=7, b=7 mid-run) -> result p=15; mid-run start/operands ignored; exactly one done.
- Reset asserted during 2nd RUN cycle -> next cycle busy=0, done=0, p=0; no done pulse afterward; a new start then yields a correct product.
- Back-to-back: start asserted in the DONE cycle with a=6, b=7 after a prior 2*3 -> p=6 at first done; RUN entered immediately; p=42 at next done; no IDLE cycle between.
- N=8 instance: a=255, b=255 -> p=65025 (16'hFE01) after 9 cycles. Sweep all 256 a,b pairs at N=4 against a*b reference.
